// File: rtl/dmem_arb_pkg.sv
// Shared types, default widths and one-hot/index helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 1000;
  localparam int MAX_CORES     = 8;
  localparam int IDX_W         = 3;

  function automatic logic [MAX_CORES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 8'd1 << idx;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_CORES; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [MAX_CORES-1:0] oh;

  // scan requesters in priority order starting at the pointer
  always_comb begin
    int pos;
    pos = 0;
    oh  = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      oh  = oh | ((!any && req[pos]) ? idx_to_onehot(3'(pos)) : 8'd0);
      any = any | req[pos];
    end
  end

  assign gnt = oh[N-1:0];
  assign idx = onehot_to_idx(oh);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port data_memory among the cores.
// Optional build macro DMEM_ARB_BOUNDS_CHECK_EN blocks accesses at or above MEM_DEPTH.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_write,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out,
  output logic                        addr_err
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t              state;
  logic [IDX_W-1:0]    prio_ptr;
  logic                acc_we;
  logic                acc_oob;

  logic [NUM_CORES-1:0] cand;
  logic [NUM_CORES-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [IDX_W-1:0]     next_ptr;

  logic                 sel_we;
  logic                 sel_ok;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  // core_gnt is zero in IDLE, so masking with it only excludes the core being served
  assign cand = core_req & ~core_gnt;

  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .req (cand),
    .ptr (prio_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // AND-OR mux of the winning core's request fields
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_we    = sel_we | (core_we[i] & pick_gnt[i]);
      sel_addr  = sel_addr  | (core_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{pick_gnt[i]}});
      sel_wdata = sel_wdata | (core_wdata[i*DATA_W +: DATA_W] & {DATA_W{pick_gnt[i]}});
    end
  end

  assign sel_ok   = !BOUNDS_EN || (32'(sel_addr) < 32'(MEM_DEPTH));
  assign next_ptr = (pick_idx == IDX_W'(NUM_CORES - 1)) ? 3'd0 : pick_idx + 3'd1;

  // access FSM: latch a winner each edge it exists, return read data one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio_ptr    <= 3'd0;
      acc_we      <= 1'b0;
      acc_oob     <= 1'b0;
      core_gnt    <= '0;
      core_rvalid <= '0;
      core_rdata  <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      addr_err    <= 1'b0;
    end else begin
      core_rvalid <= '0;
      case (state)
        ACCESS: begin
          if (!acc_we) begin
            core_rvalid <= core_gnt;
            core_rdata  <= acc_oob ? '0 : mem_data_out;
          end
        end
        IDLE:    ;
        default: ;
      endcase
      if (pick_any) begin
        state       <= ACCESS;
        prio_ptr    <= next_ptr;
        core_gnt    <= pick_gnt;
        acc_we      <= sel_we;
        acc_oob     <= !sel_ok;
        mem_address <= sel_addr;
        mem_data_in <= sel_wdata;
        mem_write   <= sel_we & sel_ok;
        mem_read    <= !sel_we & sel_ok;
        addr_err    <= !sel_ok;
      end else begin
        state     <= IDLE;
        core_gnt  <= '0;
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
        addr_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  core_req;
  logic [3:0]  core_we;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_gnt;
  logic [3:0]  core_rvalid;
  logic [15:0] core_rdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        addr_err;

  logic [15:0] tbmem   [0:65535];
  logic [15:0] ref_mem [0:65535];

  int checks = 0;
  int errors = 0;
  int rate[4];

  // transaction-level model state
  bit          m_busy;
  int          m_win;
  int          m_ptr;
  bit          m_we;
  bit          m_oob;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [3:0]  exp_rv;
  logic [15:0] exp_rdata;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .addr_err(addr_err)
  );

  assign mem_data_out = tbmem[mem_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_win = 0; m_ptr = 0; m_we = 1'b0; m_oob = 1'b0;
    m_addr = 16'd0; m_wdata = 16'd0; exp_rv = 4'd0; exp_rdata = 16'd0;
  endtask

  // one clock edge of the reference: retire current access, then grant next in pointer order
  task automatic model_edge(input logic [3:0] req_s, input logic [3:0] we_s,
                            input logic [63:0] addr_s, input logic [63:0] wdata_s);
    logic [3:0] cand;
    int pick;
    exp_rv = 4'd0;
    if (m_busy && !m_we) begin
      exp_rv    = 4'b0001 << m_win;
      exp_rdata = m_oob ? 16'd0 : ref_mem[m_addr];
    end
    if (m_busy && m_we && !m_oob) ref_mem[m_addr] = m_wdata;
    cand = req_s;
    if (m_busy) cand[m_win] = 1'b0;
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      if (pick < 0 && cand[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
    end
    if (pick >= 0) begin
      m_busy  = 1'b1;
      m_win   = pick;
      m_we    = we_s[pick];
      m_addr  = addr_s[pick*16 +: 16];
      m_wdata = wdata_s[pick*16 +: 16];
      m_oob   = BC && (m_addr >= 16'd1000);
      m_ptr   = (pick + 1) % 4;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("gnt", core_gnt, m_busy ? (4'b0001 << m_win) : 4'd0);
    chk("mem_write", mem_write, m_busy && m_we && !m_oob);
    chk("mem_read", mem_read, m_busy && !m_we && !m_oob);
    chk("addr_err", addr_err, m_busy && m_oob);
    chk("rvalid", core_rvalid, exp_rv);
    chk("rdata", core_rdata, exp_rdata);
    if (m_busy) begin
      chk("mem_address", mem_address, m_addr);
      if (m_we) chk("mem_data_in", mem_data_in, m_wdata);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, core_gnt, 4'd0);
    chk({tag, "_rvalid"}, core_rvalid, 4'd0);
    chk({tag, "_rdata"}, core_rdata, 16'd0);
    chk({tag, "_wr"}, mem_write, 1'b0);
    chk({tag, "_rd"}, mem_read, 1'b0);
    chk({tag, "_addr"}, mem_address, 16'd0);
    chk({tag, "_din"}, mem_data_in, 16'd0);
    chk({tag, "_err"}, addr_err, 1'b0);
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 5) return 16'(1000 + $urandom_range(0, 23));
    else if (r < 10) return 16'(998 + $urandom_range(0, 1));
    else return 16'($urandom_range(0, 999));
  endfunction

  task automatic set_req(input int i, input bit we, input logic [15:0] a, input logic [15:0] d);
    core_we[i] = we;
    core_addr[i*16 +: 16] = a;
    core_wdata[i*16 +: 16] = d;
    core_req[i] = 1'b1;
  endtask

  // clock, memory, model, checks, then requester behaviour
  task automatic step();
    logic pw;
    logic [15:0] pa, pd;
    logic [3:0] rq, wq;
    logic [63:0] aq, dq;
    pw = mem_write; pa = mem_address; pd = mem_data_in;
    rq = core_req; wq = core_we; aq = core_addr; dq = core_wdata;
    @(posedge clk);
    if (pw) tbmem[pa] = pd;
    if (rst_n) model_edge(rq, wq, aq, dq);
    #1;
    check_outputs();
    for (int i = 0; i < 4; i++) begin
      if (core_gnt[i]) core_req[i] = 1'b0;
      else if (!core_req[i] && $urandom_range(0, 99) < rate[i])
        set_req(i, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    core_req = 4'd0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      tbmem[i] = (i < 1024) ? 16'($urandom) : 16'd0;
      ref_mem[i] = tbmem[i];
    end
    for (int i = 0; i < 4; i++) rate[i] = 0;
    core_req = 4'd0; core_we = 4'd0; core_addr = 64'd0; core_wdata = 64'd0;
    rst_n = 1'b0;
    #1;
    do_reset();
    check_zero("reset");

    // single read: core 0 reads addr 5 holding 92
    tbmem[5] = 16'd92; ref_mem[5] = 16'd92;
    set_req(0, 1'b0, 16'd5, 16'd0);
    step();
    chk("t1_gnt", core_gnt, 4'b0001);
    chk("t1_rd", mem_read, 1'b1);
    step();
    chk("t1_rvalid", core_rvalid, 4'b0001);
    chk("t1_rdata", core_rdata, 16'd92);

    // write then read of addr 998
    set_req(2, 1'b1, 16'd998, 16'h00AB);
    step(); step();
    chk("t2_no_rvalid", core_rvalid, 4'd0);
    set_req(1, 1'b0, 16'd998, 16'd0);
    step(); step();
    chk("t2_rdata", core_rdata, 16'h00AB);
    chk("t2_rvalid", core_rvalid, 4'b0010);

    // contention from reset: all four request at once
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'(100 + i), 16'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_order", core_gnt, 4'b0001 << k);
    end
    step();
    // pointer back at 0: cores 1 and 3 together -> 1 then 3
    set_req(1, 1'b0, 16'd7, 16'd0);
    set_req(3, 1'b0, 16'd8, 16'd0);
    step();
    chk("t3_ptr_first", core_gnt, 4'b0010);
    step();
    chk("t3_ptr_second", core_gnt, 4'b1000);
    step();

    // fairness: core 0 re-requests continuously while core 3 waits
    set_req(0, 1'b0, 16'd20, 16'd0);
    set_req(3, 1'b0, 16'd21, 16'd0);
    rate[0] = 100;
    step();
    chk("t4_first", core_gnt, 4'b0001);
    step();
    chk("t4_core3", core_gnt, 4'b1000);
    step();
    chk("t4_back", core_gnt, 4'b0001);
    for (int k = 0; k < 4; k++) step();
    rate[0] = 0;
    for (int k = 0; k < 4; k++) step();

    // reset during core 1's write access to addr 10
    tbmem[10] = 16'h5555; ref_mem[10] = 16'h5555;
    set_req(1, 1'b1, 16'd10, 16'h1234);
    step();
    chk("t5_gnt", core_gnt, 4'b0010);
    chk("t5_wr", mem_write, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    model_reset();
    core_req = 4'd0;
    step();
    chk("t5_mem10", tbmem[10], 16'h5555);
    rst_n = 1'b1;

    // out-of-range read at addr 1000
    set_req(0, 1'b0, 16'd1000, 16'd0);
    step();
    chk("t6_rd", mem_read, !BC);
    chk("t6_err", addr_err, BC);
    step();
    chk("t6_rvalid", core_rvalid, 4'b0001);
    chk("t6_rdata", core_rdata, BC ? 16'd0 : ref_mem[1000]);

    // randomized traffic
    for (int i = 0; i < 4; i++) rate[i] = 40;
    for (int k = 0; k < 500; k++) step();
    for (int i = 0; i < 4; i++) rate[i] = 0;
    for (int k = 0; k < 12; k++) step();
    for (int i = 0; i < 1024; i++) begin
      if (tbmem[i] !== ref_mem[i]) chk("final_mem", tbmem[i], ref_mem[i]);
    end
    chk("final_idle", core_gnt, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
